// File: rtl/serial_adder.sv
// ---------------------------------------------------------------------------
// serial_adder
//
// Bit-serial adder: computes {cout,sum} = a + b + cin at WIDTH+1 bits,
// one bit per clock, LSB first, through a single full_adder cell.
// Operands are captured into shift registers on the accepting edge; each
// RUN edge feeds bit 0 of both shifters plus the carry flop into the cell,
// shifts the cell's sum bit into the MSB of an accumulator, and stores the
// cell's carry-out. After WIDTH RUN edges the accumulator holds the full
// sum and is copied into the result register.
//
// Ports
//   clk    in   1      rising-edge clock
//   rst    in   1      synchronous, active-high reset (highest priority)
//   start  in   1      request; accepted in IDLE or DONE, ignored in RUN
//   a      in   WIDTH  operand A, sampled on the accepting edge only
//   b      in   WIDTH  operand B, sampled on the accepting edge only
//   cin    in   1      carry-in, sampled on the accepting edge only
//   busy   out  1      high for exactly WIDTH cycles while bits are processed
//   done   out  1      one-cycle pulse when sum/cout become valid
//   sum    out  WIDTH  (a + b + cin) mod 2^WIDTH, held until next completion
//   cout   out  1      carry out of bit WIDTH-1, held with sum
//
// This file also holds the full_adder cell the serial datapath drives.
// ---------------------------------------------------------------------------

// One-bit full adder cell.
//   a, b, cin  in   1  addend bits and carry-in
//   sum, cout  out  1  sum bit and carry-out
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);
    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule

module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    // Counter value seen on the edge that processes the final bit.
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] sa_q, sa_d;
    logic [WIDTH-1:0] sb_q, sb_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic             fa_sum;
    logic             fa_cout;
    logic [WIDTH-1:0] acc_shift;

    full_adder u_fa (
        .a    (sa_q[0]),
        .b    (sb_q[0]),
        .cin  (carry_q),
        .sum  (fa_sum),
        .cout (fa_cout)
    );

    // New sum bit enters at the MSB; after WIDTH shifts bit 0 sits at the LSB.
    generate
        if (WIDTH == 1) begin : g_acc_one
            assign acc_shift = fa_sum;
        end else begin : g_acc_wide
            assign acc_shift = {fa_sum, acc_q[WIDTH-1:1]};
        end
    endgenerate

    // NOTE: every signal assigned here gets a default first so no path
    // leaves it unassigned; otherwise a latch is inferred.
    always_comb begin
        state_d = state_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        acc_d   = acc_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        cout_d  = cout_q;

        case (state_q)
            S_RUN: begin
                sa_d    = sa_q >> 1;
                sb_d    = sb_q >> 1;
                acc_d   = acc_shift;
                carry_d = fa_cout;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == LAST_BIT) begin
                    state_d = S_DONE;
                    sum_d   = acc_shift;
                    cout_d  = fa_cout;
                end
            end
            // IDLE and DONE both accept a new request; DONE otherwise
            // falls back to IDLE, giving back-to-back operation.
            default: begin
                state_d = S_IDLE;
                if (start) begin
                    state_d = S_RUN;
                    sa_d    = a;
                    sb_d    = b;
                    carry_d = cin;
                    cnt_d   = '0;
                end
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    // The accumulator and operand shifters need no reset: they are fully
    // reloaded/overwritten before their contents are ever observed.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
        end
    end

    always_ff @(posedge clk) begin
        sa_q  <= sa_d;
        sb_q  <= sb_d;
        acc_q <= acc_d;
    end

    // Status outputs decode straight from the state flops.
    assign busy = (state_q == S_RUN);
    assign done = (state_q == S_DONE);
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// ---------------------------------------------------------------------------
// tb_serial_adder
//
// Drives three serial_adder instances (WIDTH = 8, 4, 1) from directed
// vectors. A cycle-level reference model tracks each instance as "idle or
// N cycles remaining" with the arithmetic result computed up front; one
// compare process checks busy/done/sum/cout of every instance each cycle,
// and a few literal results pin the model on the WIDTH=8 instance.
// ---------------------------------------------------------------------------
module tb_serial_adder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [7:0] a_drv     [3];
    logic [7:0] b_drv     [3];
    logic       cin_drv   [3];
    logic       start_drv [3];

    logic [2:0] busy_w, done_w, cout_w;
    logic [7:0] sum8;
    logic [3:0] sum4;
    logic [0:0] sum1;

    serial_adder #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start_drv[0]),
        .a(a_drv[0]), .b(b_drv[0]), .cin(cin_drv[0]),
        .busy(busy_w[0]), .done(done_w[0]), .sum(sum8), .cout(cout_w[0])
    );

    serial_adder #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .start(start_drv[1]),
        .a(a_drv[1][3:0]), .b(b_drv[1][3:0]), .cin(cin_drv[1]),
        .busy(busy_w[1]), .done(done_w[1]), .sum(sum4), .cout(cout_w[1])
    );

    serial_adder #(.WIDTH(1)) dut1 (
        .clk(clk), .rst(rst), .start(start_drv[2]),
        .a(a_drv[2][0:0]), .b(b_drv[2][0:0]), .cin(cin_drv[2]),
        .busy(busy_w[2]), .done(done_w[2]), .sum(sum1), .cout(cout_w[2])
    );

    function automatic int width_of(input int i);
        return (i == 0) ? 8 : (i == 1) ? 4 : 1;
    endfunction

    // ---------------- reference model ----------------
    // rem = cycles of processing left (0 = not busy). pend = a+b+cin.
    int         rem    [3];
    int         pend   [3];
    logic       m_done [3];
    logic [7:0] m_sum  [3];
    logic       m_cout [3];

    initial begin
        for (int i = 0; i < 3; i++) begin
            rem[i] = 0; pend[i] = 0; m_done[i] = 1'b0;
            m_sum[i] = '0; m_cout[i] = 1'b0;
        end
    end

    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            automatic int w    = width_of(i);
            automatic int mask = (1 << w) - 1;
            if (rst) begin
                rem[i]    <= 0;
                m_done[i] <= 1'b0;
                m_sum[i]  <= '0;
                m_cout[i] <= 1'b0;
            end else if (rem[i] == 0) begin
                m_done[i] <= 1'b0;
                if (start_drv[i]) begin
                    pend[i] <= (int'(a_drv[i]) & mask) + (int'(b_drv[i]) & mask)
                               + int'(cin_drv[i]);
                    rem[i]  <= w;
                end
            end else begin
                rem[i]    <= rem[i] - 1;
                m_done[i] <= (rem[i] == 1);
                if (rem[i] == 1) begin
                    m_sum[i]  <= 8'(pend[i] & mask);
                    m_cout[i] <= ((pend[i] >> w) & 1) == 1;
                end
            end
        end
    end

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input int inst, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s[w%0d] @%0t: got %0h expected %0h",
                     name, width_of(inst), $time, act, exp);
        end
    endtask

    // Literal expectations for the next WIDTH=8 done pulse.
    logic       lit_valid = 1'b0;
    logic [7:0] lit_sum   = '0;
    logic       lit_cout  = 1'b0;

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            automatic int act_sum = (i == 0) ? int'(sum8) : (i == 1) ? int'(sum4) : int'(sum1);
            check("busy", i, int'(busy_w[i]), int'(rem[i] != 0));
            check("done", i, int'(done_w[i]), int'(m_done[i]));
            check("sum",  i, act_sum,         int'(m_sum[i]));
            check("cout", i, int'(cout_w[i]), int'(m_cout[i]));
        end
        if (lit_valid && done_w[0]) begin
            check("lit_sum",  0, int'(sum8),      int'(lit_sum));
            check("lit_cout", 0, int'(cout_w[0]), int'(lit_cout));
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic c,
                       input logic [7:0] es, input logic ec);
        lit_sum = es; lit_cout = ec; lit_valid = 1'b1;
        a_drv[0] = a; b_drv[0] = b; cin_drv[0] = c; start_drv[0] = 1'b1;
        tick(1);
        start_drv[0] = 1'b0;
        tick(10);
        lit_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            a_drv[i] = '0; b_drv[i] = '0; cin_drv[i] = 1'b0; start_drv[i] = 1'b0;
        end
        tick(2);
        rst = 1'b0;
        tick(1);

        // Zeros, carry ripple, then a value that must be held while idle.
        op8(8'h00, 8'h00, 1'b0, 8'h00, 1'b0);
        op8(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
        op8(8'h3C, 8'h42, 1'b1, 8'h7F, 1'b0);
        tick(4);

        // start held high, operands changing every cycle.
        start_drv[0] = 1'b1;
        for (int k = 0; k < 27; k++) begin
            a_drv[0]   = 8'($urandom);
            b_drv[0]   = 8'($urandom);
            cin_drv[0] = 1'($urandom);
            tick(1);
        end
        start_drv[0] = 1'b0;
        tick(10);

        // Reset on the 4th RUN edge aborts the operation.
        a_drv[0] = 8'hAA; b_drv[0] = 8'h55; cin_drv[0] = 1'b0; start_drv[0] = 1'b1;
        tick(1);
        start_drv[0] = 1'b0;
        tick(3);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        tick(12);
        op8(8'h80, 8'h80, 1'b0, 8'h00, 1'b1);

        // Reset and start on the same edge: stays idle.
        a_drv[0] = 8'h12; b_drv[0] = 8'h34; start_drv[0] = 1'b1; rst = 1'b1;
        tick(1);
        rst = 1'b0; start_drv[0] = 1'b0;
        tick(3);

        // WIDTH=4: all 512 combinations back-to-back.
        start_drv[1] = 1'b1;
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                for (int c = 0; c < 2; c++) begin
                    a_drv[1] = 8'(a); b_drv[1] = 8'(b); cin_drv[1] = 1'(c);
                    tick(5);
                end
            end
        end
        start_drv[1] = 1'b0;
        tick(7);

        // WIDTH=1: all 8 combinations back-to-back.
        start_drv[2] = 1'b1;
        for (int v = 0; v < 8; v++) begin
            a_drv[2] = 8'(v & 1); b_drv[2] = 8'((v >> 1) & 1); cin_drv[2] = 1'((v >> 2) & 1);
            tick(2);
        end
        start_drv[2] = 1'b0;
        tick(4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
